// File: rtl/wsel_pkg.sv
// Shared types and default widths for the write-select burst decoder.
package wsel_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  localparam int ADDR_W_DEF  = 3;
  localparam int NUM_SEL_DEF = 8;

endpackage

// File: rtl/onehot_dec.sv
// Combinational address to one-hot decoder; out-of-range addresses decode to zero.
module onehot_dec
  import wsel_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int NUM_SEL = NUM_SEL_DEF
) (
  input  logic [ADDR_W-1:0]  addr_i,
  output logic [NUM_SEL-1:0] onehot_o,
  output logic               valid_o
);

  // One extra bit so NUM_SEL == 2**ADDR_W is representable.
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(NUM_SEL);

  always_comb begin
    onehot_o = '0;
    for (int i = 0; i < NUM_SEL; i++) begin
      if (addr_i == ADDR_W'(i)) onehot_o[i] = 1'b1;
    end
    valid_o = ({1'b0, addr_i} < LIMIT);
  end

endmodule

// File: rtl/wsel_burst_dec.sv
// Registered write-select decoder with valid/ready request port and auto-incrementing bursts.
// Build option: define WSEL_ERR_STICKY_EN to hold Err_o high until reset.
module wsel_burst_dec
  import wsel_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int NUM_SEL = NUM_SEL_DEF,
  parameter int LEN_W   = 3
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [ADDR_W-1:0]  A_i,
  input  logic [LEN_W-1:0]   Len_i,
  input  logic               Valid_i,
  output logic               Ready_o,
  input  logic               Abort_i,
  input  logic               EN_i,
  output logic [NUM_SEL-1:0] Sel_o,
  output logic               Done_o,
  output logic               Err_o,
  output state_e             state_o
);

  // Handshake: a request is taken on any rising edge where Valid_i && Ready_o;
  // Ready_o depends only on state, never on Valid_i.

`ifdef WSEL_ERR_STICKY_EN
  localparam bit ERR_STICKY = 1'b1;
`else
  localparam bit ERR_STICKY = 1'b0;
`endif

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_SEL - 1);

  state_e               state_q;
  logic [NUM_SEL-1:0]   sel_q;
  logic                 done_q;
  logic                 err_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [LEN_W-1:0]     remain_q;

  logic                 accept;
  logic [ADDR_W-1:0]    addr_mux;
  logic [ADDR_W-1:0]    addr_inc;
  logic [NUM_SEL-1:0]   dec_onehot;
  logic                 dec_valid;

  always_comb begin
    accept   = Valid_i && (state_q == IDLE);
    addr_mux = (state_q == BURST) ? addr_q : A_i;
    addr_inc = (addr_mux == LAST_ADDR) ? '0 : addr_mux + ADDR_W'(1);
  end

  onehot_dec #(
    .ADDR_W  (ADDR_W),
    .NUM_SEL (NUM_SEL)
  ) u_dec (
    .addr_i   (addr_mux),
    .onehot_o (dec_onehot),
    .valid_o  (dec_valid)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      addr_q   <= '0;
      remain_q <= '0;
    end else begin
      err_q <= ERR_STICKY & err_q;
      case (state_q)
        IDLE: begin
          sel_q  <= '0;
          done_q <= 1'b0;
          if (accept) begin
            if (!dec_valid) begin
              // Rejected start address: report and finish without a burst.
              err_q  <= 1'b1;
              done_q <= 1'b1;
            end else begin
              sel_q    <= dec_onehot;
              addr_q   <= addr_inc;
              remain_q <= Len_i;
              if (Len_i == '0) begin
                done_q <= 1'b1;
              end else begin
                state_q <= BURST;
              end
            end
          end
        end
        BURST: begin
          if (Abort_i) begin
            sel_q   <= '0;
            done_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            sel_q    <= dec_onehot;
            addr_q   <= addr_inc;
            remain_q <= remain_q - LEN_W'(1);
            if (remain_q == LEN_W'(1)) begin
              done_q  <= 1'b1;
              state_q <= IDLE;
            end else begin
              done_q <= 1'b0;
            end
          end
        end
        default: begin
          sel_q   <= '0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign Ready_o = (state_q == IDLE);
  assign Sel_o   = sel_q & {NUM_SEL{EN_i}};
  assign Done_o  = done_q;
  assign Err_o   = err_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_wsel_burst_dec.sv
// Directed bench for wsel_burst_dec: an 8-select instance plus a 6-select instance for range errors.
module tb_wsel_burst_dec;
  import wsel_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] a = '0;
  logic [2:0] len = '0;
  logic       valid = 1'b0;
  logic       abort = 1'b0;
  logic       en = 1'b1;

  logic [7:0] sel;
  logic       ready, done, err;
  state_e     st;
  logic [5:0] sel6;
  logic       ready6, done6, err6;
  state_e     st6;

  int n_assert = 0;
  int n_fail   = 0;

  wsel_burst_dec #(.ADDR_W(3), .NUM_SEL(8), .LEN_W(3)) dut (
    .clk_i(clk), .rst_i(rst), .A_i(a), .Len_i(len), .Valid_i(valid),
    .Ready_o(ready), .Abort_i(abort), .EN_i(en), .Sel_o(sel),
    .Done_o(done), .Err_o(err), .state_o(st)
  );

  wsel_burst_dec #(.ADDR_W(3), .NUM_SEL(6), .LEN_W(3)) dut6 (
    .clk_i(clk), .rst_i(rst), .A_i(a), .Len_i(len), .Valid_i(valid),
    .Ready_o(ready6), .Abort_i(abort), .EN_i(en), .Sel_o(sel6),
    .Done_o(done6), .Err_o(err6), .state_o(st6)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; valid = 1'b0; abort = 1'b0; en = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_assert++;
    if ({sel, done, err, ready} !== {8'h00, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset: sel/done/err/ready got %h/%b/%b/%b want 00/0/0/1", sel, done, err, ready);
    end
  endtask

  task automatic test_single();
    valid = 1'b1; a = 3'd3; len = 3'd0; en = 1'b1;
    tick();
    valid = 1'b0;
    n_assert++;
    if ({sel, done, ready} !== {8'b0000_1000, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL single: sel/done/ready got %h/%b/%b want 08/1/1", sel, done, ready);
    end
    tick();
    n_assert++;
    if ({sel, done, ready} !== {8'h00, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL single_idle: sel/done/ready got %h/%b/%b want 00/0/1", sel, done, ready);
    end
  endtask

  task automatic test_burst_wrap();
    logic [7:0] exp_sel [4];
    logic       exp_done [4];
    logic       exp_rdy [4];
    exp_sel  = '{8'h40, 8'h80, 8'h01, 8'h02};
    exp_done = '{1'b0, 1'b0, 1'b0, 1'b1};
    exp_rdy  = '{1'b0, 1'b0, 1'b0, 1'b1};
    valid = 1'b1; a = 3'd6; len = 3'd3;
    for (int i = 0; i < 4; i++) begin
      tick();
      valid = 1'b0;
      n_assert++;
      if ({sel, done, ready} !== {exp_sel[i], exp_done[i], exp_rdy[i]}) begin
        n_fail++;
        $display("FAIL burst_wrap beat %0d: sel/done/ready got %h/%b/%b want %h/%b/%b",
                 i, sel, done, ready, exp_sel[i], exp_done[i], exp_rdy[i]);
      end
    end
    tick();
    n_assert++;
    if ({sel, done} !== {8'h00, 1'b0}) begin
      n_fail++;
      $display("FAIL burst_wrap_end: sel/done got %h/%b want 00/0", sel, done);
    end
  endtask

  task automatic test_range_err();
    logic exp_late;
`ifdef WSEL_ERR_STICKY_EN
    exp_late = 1'b1;
`else
    exp_late = 1'b0;
`endif
    do_reset();
    valid = 1'b1; a = 3'd7; len = 3'd0;
    tick();
    valid = 1'b0;
    n_assert++;
    if ({sel6, err6, done6, ready6} !== {6'h00, 1'b1, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL range_err: sel/err/done/ready got %h/%b/%b/%b want 00/1/1/1", sel6, err6, done6, ready6);
    end
    tick();
    n_assert++;
    if ({sel6, done6} !== {6'h00, 1'b0}) begin
      n_fail++;
      $display("FAIL range_err_next: sel/done got %h/%b want 00/0", sel6, done6);
    end
    for (int i = 0; i < 9; i++) tick();
    n_assert++;
    if (err6 !== exp_late) begin
      n_fail++;
      $display("FAIL range_err_hold: err got %b want %b", err6, exp_late);
    end
    do_reset();
  endtask

  task automatic test_abort();
    valid = 1'b1; a = 3'd0; len = 3'd5;
    tick();
    valid = 1'b0;
    n_assert++;
    if ({sel, ready} !== {8'h01, 1'b0}) begin
      n_fail++;
      $display("FAIL abort_beat0: sel/ready got %h/%b want 01/0", sel, ready);
    end
    tick();
    abort = 1'b1;
    n_assert++;
    if ({sel, done} !== {8'h02, 1'b0}) begin
      n_fail++;
      $display("FAIL abort_beat1: sel/done got %h/%b want 02/0", sel, done);
    end
    tick();
    abort = 1'b0;
    n_assert++;
    if ({sel, done, ready} !== {8'h00, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL abort_stop: sel/done/ready got %h/%b/%b want 00/0/1", sel, done, ready);
    end
    tick();
    n_assert++;
    if ({sel, done} !== {8'h00, 1'b0}) begin
      n_fail++;
      $display("FAIL abort_quiet: sel/done got %h/%b want 00/0", sel, done);
    end
  endtask

  task automatic test_en_gate();
    valid = 1'b1; a = 3'd1; len = 3'd2;
    tick();
    valid = 1'b0;
    n_assert++;
    if ({sel, done} !== {8'h02, 1'b0}) begin
      n_fail++;
      $display("FAIL en_beat0: sel/done got %h/%b want 02/0", sel, done);
    end
    en = 1'b0;
    tick();
    n_assert++;
    if ({sel, done} !== {8'h00, 1'b0}) begin
      n_fail++;
      $display("FAIL en_beat1: sel/done got %h/%b want 00/0", sel, done);
    end
    en = 1'b1;
    tick();
    n_assert++;
    if ({sel, done, ready} !== {8'h08, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL en_beat2: sel/done/ready got %h/%b/%b want 08/1/1", sel, done, ready);
    end
  endtask

  task automatic test_back_to_back();
    valid = 1'b1; a = 3'd2; len = 3'd4;
    tick();
    valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_assert++;
    if ({sel, done, err, ready} !== {8'h00, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL rst_mid: sel/done/err/ready got %h/%b/%b/%b want 00/0/0/1", sel, done, err, ready);
    end
    valid = 1'b1; a = 3'd5; len = 3'd1;
    tick();
    valid = 1'b0;
    n_assert++;
    if ({sel, done, ready} !== {8'h20, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL b2b_first0: sel/done/ready got %h/%b/%b want 20/0/0", sel, done, ready);
    end
    tick();
    n_assert++;
    if ({sel, done, ready} !== {8'h40, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL b2b_first1: sel/done/ready got %h/%b/%b want 40/1/1", sel, done, ready);
    end
    valid = 1'b1; a = 3'd0; len = 3'd1;
    tick();
    valid = 1'b0;
    n_assert++;
    if ({sel, done, ready} !== {8'h01, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL b2b_second0: sel/done/ready got %h/%b/%b want 01/0/0", sel, done, ready);
    end
    tick();
    n_assert++;
    if ({sel, done, ready} !== {8'h02, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL b2b_second1: sel/done/ready got %h/%b/%b want 02/1/1", sel, done, ready);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst_wrap();
    test_range_err();
    test_abort();
    test_en_gate();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
